smi_arbiter: RTL
================

Name: smi_arbiter

Overview:
- Shares the single SMI request/response port of the SCR file between N_REQ independent requesters (host bridge, debug port, on-chip controllers).
- Round-robin arbitration with exactly one outstanding transaction at a time, matching the SCR file's one-in-flight behaviour.
- Tracks the owner of the in-flight transaction and steers its response back to that requester.
- Sits directly in front of the SCR file's SMI port; requester side and SCR side use identical valid/ready SMI semantics.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- ADDR_W, 6, SMI address width (64 SCRs)
- DATA_W, 64, SMI data width
- IDX_W, $clog2(N_REQ), grant index width (derived, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rq_req_valid  in  N_REQ  per-requester request valid
- rq_req_ready  out  N_REQ  per-requester request accepted
- rq_req_rw  in  N_REQ  per-requester 1=write, 0=read
- rq_req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- rq_req_data  in  N_REQ*DATA_W  packed write data, same packing
- rq_resp_valid  out  N_REQ  per-requester response valid
- rq_resp_ready  in  N_REQ  per-requester response ready
- rq_resp_bits  out  DATA_W  response data, broadcast to all requesters, qualified by rq_resp_valid
- smi_req_valid  out  1  to SCR file
- smi_req_ready  in  1  from SCR file
- smi_req_bits_rw  out  1
- smi_req_bits_addr  out  ADDR_W
- smi_req_bits_data  out  DATA_W
- smi_resp_valid  in  1  from SCR file
- smi_resp_ready  out  1  to SCR file
- smi_resp_bits  in  DATA_W  from SCR file
- busy  out  1  state != IDLE
- grant_idx  out  IDX_W  registered owner of the current or last transaction

Behaviour:
- Clocking and reset: one clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, grant_idx=0, rr_ptr=0, busy=0. All valid/ready outputs are 0 in IDLE; smi_req_bits_* = 0 when not in REQ.
- States:
  - IDLE: no transaction.
  - REQ: presenting the granted request to the SCR file.
  - RESP: waiting for and returning the response.
- Arbitration, evaluated in IDLE, and in RESP on the cycle the response fires:
  - Winner = first i with rq_req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - If a winner exists: grant_idx<=winner, rr_ptr<=(winner+1) mod N_REQ, next=REQ.
  - Otherwise next=IDLE.
  - Arbitration inputs are never combinationally reflected to SMI outputs in the same cycle; grant is registered.
- REQ:
  - smi_req_valid=1; rw/addr/data muxed from requester grant_idx.
  - rq_req_ready[grant_idx]=smi_req_ready; all other rq_req_ready=0.
  - On smi_req_valid&smi_req_ready, next=RESP.
  - Requesters must hold valid and fields stable until ready (standard valid/ready rule); behaviour on violation is undefined.
- RESP:
  - rq_resp_valid[grant_idx]=smi_resp_valid; rq_resp_bits=smi_resp_bits; smi_resp_ready=rq_resp_ready[grant_idx]; all others 0.
  - Every accepted request, read or write, receives exactly one response.
  - On response fire, re-arbitrate as above (back-to-back: RESP→REQ with no IDLE bubble).
  - A request from the same requester that just completed is eligible but has lowest priority.
- Latency: request valid in IDLE → smi_req_valid 1 cycle later. The SCR file returns its response ≥1 cycle after accept. Minimum sustained period is 2 cycles per transaction with ready always high.
- Simultaneous events:
  - New requests arriving in REQ/RESP wait; they are never dropped.
  - smi_resp_valid arriving in REQ is not possible with a compliant SCR file and is ignored.
- Reset mid-operation: returns to IDLE immediately. The in-flight response is discarded; the SCR file shares the same reset.
- No starvation: any continuously valid requester is granted within N_REQ transactions.

Decomposition:
- Shared package smi_pkg: ADDR_W/DATA_W defaults and the state enum (IDLE/REQ/RESP).
- Sub-module rr_pick (combinational): N_REQ valid vector + rr_ptr → winner index + found flag. Reusable by other arbiters.

Test Plan:
- Single read: reset, then rq_req_valid[2]=1, rw=0, addr=0x05. Expect smi_req_valid the next cycle with addr 0x05; SCR returns 0xDEAD_BEEF_0000_0005; only rq_resp_valid[2] asserts, with that data; grant_idx=2.
- All four requesters valid continuously from reset. Expect grant order 0,1,2,3,0; back-to-back with no IDLE cycle between response fire and the next smi_req_valid.
- Write then read, same requester 1: write addr 0x3F data 0x1234. Expect smi_req_bits_rw=1, data 0x1234, and a response consumed on rq_resp_valid[1]. A subsequent read of 0x3F is granted after any pending higher-rotation requester.
- Backpressure: smi_req_ready=0 for 5 cycles. Expect smi_req_valid and fields held and rq_req_ready all 0. Then rq_resp_ready[0]=0 for 3 cycles: expect smi_resp_ready=0 and rq_resp_valid[0] held.
- Late arrival: requester 3 asserts valid while in RESP for requester 0. Expect 3 granted immediately on response fire, ahead of requester 0's new request.
- Reset in RESP: reset asserted for 1 cycle. Expect state IDLE, busy=0, all rq_resp_valid=0 next cycle, rr_ptr=0 (next grant goes to lowest valid index).

Source files
------------

// File: rtl/smi_pkg.sv
// Shared SMI definitions: default bus widths and the arbiter state encoding.
package smi_pkg;

  localparam int unsigned SMI_ADDR_W = 6;
  localparam int unsigned SMI_DATA_W = 64;

  typedef logic [1:0] smi_state_t;

  localparam smi_state_t StIdle = 2'd0;
  localparam smi_state_t StReq  = 2'd1;
  localparam smi_state_t StResp = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && valid_i[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

  assign idx_o   = idx;
  assign found_o = found;

endmodule

// File: rtl/smi_arbiter.sv
// Round-robin arbiter sharing one SMI port between N_REQ requesters, one transaction in flight,
// with the response steered back to the registered owner.
module smi_arbiter
  import smi_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = SMI_ADDR_W,
  parameter int unsigned DATA_W = SMI_DATA_W,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          rq_req_valid,
  output logic [N_REQ-1:0]          rq_req_ready,
  input  logic [N_REQ-1:0]          rq_req_rw,
  input  logic [N_REQ*ADDR_W-1:0]   rq_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   rq_req_data,
  output logic [N_REQ-1:0]          rq_resp_valid,
  input  logic [N_REQ-1:0]          rq_resp_ready,
  output logic [DATA_W-1:0]         rq_resp_bits,
  output logic                      smi_req_valid,
  input  logic                      smi_req_ready,
  output logic                      smi_req_bits_rw,
  output logic [ADDR_W-1:0]         smi_req_bits_addr,
  output logic [DATA_W-1:0]         smi_req_bits_data,
  input  logic                      smi_resp_valid,
  output logic                      smi_resp_ready,
  input  logic [DATA_W-1:0]         smi_resp_bits,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx
);

  smi_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             resp_fire;
  logic             arb_en;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid_i (rq_req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign resp_fire = (state_q == StResp) && smi_resp_valid && rq_resp_ready[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    arb_en  = 1'b0;
    case (state_q)
      StIdle: arb_en = 1'b1;
      StReq:  if (smi_req_ready) state_d = StResp;
      StResp: arb_en = resp_fire;
      default: state_d = StIdle;
    endcase
    // Re-arbitrating on response fire gives back-to-back grants without an idle bubble.
    if (arb_en) begin
      if (win_found) begin
        state_d = StReq;
        grant_d = win_idx;
        ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    rq_req_ready      = '0;
    rq_resp_valid     = '0;
    rq_resp_bits      = '0;
    smi_req_valid     = 1'b0;
    smi_req_bits_rw   = 1'b0;
    smi_req_bits_addr = '0;
    smi_req_bits_data = '0;
    smi_resp_ready    = 1'b0;
    case (state_q)
      StReq: begin
        smi_req_valid          = 1'b1;
        smi_req_bits_rw        = rq_req_rw[grant_q];
        smi_req_bits_addr      = rq_req_addr[grant_q*ADDR_W +: ADDR_W];
        smi_req_bits_data      = rq_req_data[grant_q*DATA_W +: DATA_W];
        rq_req_ready[grant_q]  = smi_req_ready;
      end
      StResp: begin
        rq_resp_valid[grant_q] = smi_resp_valid;
        rq_resp_bits           = smi_resp_bits;
        smi_resp_ready         = rq_resp_ready[grant_q];
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign grant_idx = grant_q;

endmodule
